// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier. It retires one Booth digit per clock and
// handles signed and unsigned operands. P is registered and changes only when an
// operation completes or on reset. done pulses for one cycle with the valid product.
// WIDTH must be even and at least 4.
module booth_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic [2*WIDTH-1:0]   P,
  output logic                 done,
  output logic                 busy,
  output logic [2:0]           g,
  output logic [2*WIDTH-1:0]   pp
);

  localparam int unsigned PW = 2 * WIDTH;
  // Y extended by two bits and with y[-1] = 0 appended at the bottom.
  localparam int unsigned YW = WIDTH + 3;
  localparam int unsigned CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LastSigned   = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] LastUnsigned = CW'(WIDTH / 2);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   last_q;
  logic [PW-1:0]   p_q;
  logic            done_q;
  logic [2:0]      g_q;
  logic [PW-1:0]   pp_q;

  logic [YW-1:0]   y_sh;
  logic [2:0]      grp;
  logic [PW-1:0]   digit;
  logic [PW-1:0]   pp_d;
  logic [PW-1:0]   acc_sum;
  logic            last_iter;
  logic            y_ext_bit;
  logic [PW-1:0]   x_ext;

  // Booth group selection, digit decode and accumulation for the current iteration.
  always_comb begin
    y_sh  = y_q >> {cnt_q, 1'b0};
    grp   = y_sh[2:0];
    digit = '0;
    case (grp)
      3'b001, 3'b010: digit = x_q;
      3'b011:         digit = x_q << 1;
      3'b100:         digit = -(x_q << 1);
      3'b101, 3'b110: digit = -x_q;
      default:        digit = '0;
    endcase
    pp_d      = digit << {cnt_q, 1'b0};
    acc_sum   = acc_q + pp_d;
    last_iter = (cnt_q == last_q);
  end

  // Operand extension applied at capture time.
  always_comb begin
    y_ext_bit = signed_mode & Y[WIDTH-1];
    x_ext     = signed_mode ? {{WIDTH{X[WIDTH-1]}}, X} : {{WIDTH{1'b0}}, X};
  end

  // Next-state logic. Start is only looked at in idle, so a start while busy is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StCalc;
      StCalc: if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register. Reset takes priority over start and over iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: capture operands on start, then run one Booth iteration per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
      g_q    <= '0;
      pp_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q    <= x_ext;
            y_q    <= {y_ext_bit, y_ext_bit, Y, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
            // Unsigned needs one extra digit to absorb the zero-extended top bits.
            last_q <= signed_mode ? LastSigned : LastUnsigned;
          end
        end
        StCalc: begin
          g_q   <= grp;
          pp_q  <= pp_d;
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            p_q    <= acc_sum;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = (state_q == StCalc);
  assign g    = g_q;
  assign pp   = pp_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
module tb_booth_seq_mult;

  localparam int unsigned WIDTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     X;
  logic [WIDTH-1:0]     Y;
  logic [2*WIDTH-1:0]   P;
  logic                 done;
  logic                 busy;
  logic [2:0]           g;
  logic [2*WIDTH-1:0]   pp;

  int n_pass;
  int n_total;

  // Values sampled after the first iteration edge of the latest do_mult call.
  logic [2:0]           g_first;
  logic [2*WIDTH-1:0]   pp_first;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .X           (X),
    .Y           (Y),
    .P           (P),
    .done        (done),
    .busy        (busy),
    .g           (g),
    .pp          (pp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply and return in the sample after the done edge (the done cycle).
  // Inputs are scrambled after capture to show they no longer matter.
  task automatic do_mult(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_p, input int exp_lat);
    int lat;
    int busy_cnt;
    int p_changes;
    logic [15:0] p_prev;
    p_prev      = P;
    start       = 1'b1;
    signed_mode = sm;
    X           = a;
    Y           = b;
    tick();
    start       = 1'b0;
    signed_mode = ~sm;
    X           = 8'($urandom);
    Y           = 8'($urandom);
    lat       = 0;
    busy_cnt  = 0;
    p_changes = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (P !== p_prev) p_changes++;
      tick();
      lat++;
      if (lat == 1) begin
        g_first  = g;
        pp_first = pp;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " P"}, P, exp_p);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " busy in done cycle"}, busy, 1'b0);
    check({tag, " P held while busy"}, p_changes, 0);
  endtask

  int dones;
  int lat;

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    X           = '0;
    Y           = '0;
    tick();
    tick();
    check("reset P", P, 16'h0000);
    check("reset done", done, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset g", g, 3'b000);
    check("reset pp", pp, 16'h0000);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    X     = 8'h11;
    Y     = 8'h22;
    tick();
    check("rst over start busy", busy, 1'b0);
    start = 1'b0;
    rst   = 1'b0;
    // Start in the first cycle after reset release.
    do_mult("s 80x80", 1'b1, 8'h80, 8'h80, 16'h4000, 4);
    tick();
    check("done one cycle", done, 1'b0);

    do_mult("u FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 5);
    do_mult("s FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001, 4);
    do_mult("s 7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080, 4);
    do_mult("s 05xFD", 1'b1, 8'h05, 8'hFD, 16'hFFF1, 4);
    // First group of Y=FD is 010 -> +X = 5.
    check("first g", g_first, 3'b010);
    check("first pp", pp_first, 16'h0005);
    check("last g", g, 3'b111);
    check("last pp", pp, 16'h0000);
    // Back-to-back: start issued in the done cycle.
    do_mult("b2b FExFE03", 1'b1, 8'hFE, 8'h03, 16'hFFFA, 4);
    tick();

    // Start while busy must be ignored.
    start       = 1'b1;
    signed_mode = 1'b0;
    X           = 8'd3;
    Y           = 8'd5;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    X     = 8'd7;
    Y     = 8'd7;
    tick();
    start = 1'b0;
    X     = 8'd0;
    Y     = 8'd0;
    lat   = 2;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("busy start latency", lat, 5);
    check("busy start P", P, 16'h000F);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("busy start extra done", dones, 0);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1;
    X     = 8'd9;
    Y     = 8'd9;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort P", P, 16'h0000);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    do_mult("after abort 2x3", 1'b0, 8'd2, 8'd3, 16'h0006, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
